// File: rtl/fp_seq_pkg.sv
// fp_seq_pkg: shared types and constants for the FP adder operand sequencer
package fp_seq_pkg;

  typedef logic [31:0] fp32_t;

  typedef struct packed {
    fp32_t a;
    fp32_t b;
  } operand_pair_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    WAIT_BUSY,
    WAIT_DONE
  } seq_state_t;

  localparam fp32_t FP_POS_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fp_pair_fifo.sv
// fp_pair_fifo: synchronous FIFO of operand pairs with full/empty flags
module fp_pair_fifo
  import fp_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_push,
  input  operand_pair_t i_data,
  input  logic          i_pop,
  output operand_pair_t o_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  operand_pair_t r_mem [DEPTH];
  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;
  logic          w_wen;
  logic          w_ren;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bit means full.
  assign o_empty = r_wr == r_rd;
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_data  = r_mem[r_rd[AW-1:0]];
  assign w_wen   = i_push && !o_full;
  assign w_ren   = i_pop && !o_empty;

  // Advance read and write pointers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wen) r_wr <= r_wr + (AW+1)'(1);
      if (w_ren) r_rd <= r_rd + (AW+1)'(1);
    end
  end

  // Storage is not reset; contents are only visible once written
  always_ff @(posedge clock) begin
    if (w_wen) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/fp_operand_sequencer.sv
// fp_operand_sequencer: buffers operand pairs and serialises them onto the FP adder bus; optional watchdog via FP_SEQ_TIMEOUT_EN
module fp_operand_sequencer
  import fp_seq_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  in_valid,
  input  fp32_t in_a,
  input  fp32_t in_b,
  output logic  in_ready,
  input  logic  adder_ready,
  output fp32_t a,
  input  fp32_t sum,
  output logic  out_valid,
  output fp32_t out_sum,
  input  logic  out_ready
`ifdef FP_SEQ_TIMEOUT_EN
  ,
  output logic  timeout
`endif
);

  seq_state_t    r_state;
  seq_state_t    w_next;
  operand_pair_t r_pair;
  operand_pair_t w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_done;
  logic          w_expire;
  logic          r_out_valid;
  fp32_t         r_out_sum;

  assign in_ready  = !w_full;
  assign w_push    = in_valid && !w_full;
  assign w_pop     = (r_state == IDLE) && (w_next == LOAD_A);
  assign w_done    = (r_state == WAIT_DONE) && adder_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;

  fp_pair_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .i_push (w_push),
    .i_data ('{a: in_a, b: in_b}),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

`ifdef FP_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_timeout;
  logic          w_wait;

  assign w_wait   = (r_state == WAIT_BUSY) || (r_state == WAIT_DONE);
  // A result arriving on the last allowed cycle still wins over the watchdog
  assign w_expire = w_wait && (r_cnt == CW'(TIMEOUT_CYCLES - 1)) && !w_done;
  assign timeout  = r_timeout;

  // Watchdog counts cycles spent in the current wait state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= (w_next != r_state || !w_wait) ? '0 : r_cnt + CW'(1);
      r_timeout <= w_expire;
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  // Next-state selection and operand bus drive
  always_comb begin
    w_next = r_state;
    a      = FP_POS_ZERO;
    case (r_state)
      IDLE:      if (!w_empty && adder_ready && !r_out_valid) w_next = LOAD_A;
      LOAD_A: begin
        a      = r_pair.a;
        w_next = LOAD_B;
      end
      LOAD_B: begin
        a      = r_pair.b;
        w_next = WAIT_BUSY;
      end
      WAIT_BUSY: if (!adder_ready) w_next = WAIT_DONE;
      WAIT_DONE: if (adder_ready) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
    if (w_expire) w_next = IDLE;
  end

  // State register, popped pair and held result
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pair      <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= FP_POS_ZERO;
    end else begin
      r_state <= w_next;
      if (w_pop) r_pair <= w_head;
      if (w_done) begin
        r_out_valid <= 1'b1;
        r_out_sum   <= sum;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fp_operand_sequencer.md
Name: fp_operand_sequencer

Overview:
Upstream feeder for the 32-bit FP adder. It buffers operand pairs from a valid/ready producer and serialises each pair onto the adder's single 32-bit operand bus using the adder's two-cycle load protocol. It then waits for the adder to finish, captures the sum, and presents it on a valid/ready result port. At most one addition is in flight at a time.

Parameters:
DEPTH, 4, operand-pair FIFO entries (power of two, >=2)
TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with FP_SEQ_TIMEOUT_EN)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  producer has an operand pair
in_a  in  32  first operand, IEEE-754 single
in_b  in  32  second operand, IEEE-754 single
in_ready  out  1  FIFO not full
adder_ready  in  1  adder idle/result-valid level
a  out  32  operand bus to adder
sum  in  32  adder result
out_valid  out  1  result held
out_sum  out  32  captured sum
out_ready  in  1  consumer accepts result
timeout  out  1  watchdog pulse (FP_SEQ_TIMEOUT_EN only)

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: a=0, out_valid=0, out_sum=0, in_ready=1, timeout=0, FIFO empty, state=IDLE.
- Reset asserted mid-operation aborts the operation. The FIFO and held result are discarded.
- Push: a pair is written when in_valid && in_ready. in_ready = !full.
- Pop: occurs on the IDLE->LOAD_A transition only.
- Simultaneous push and pop when full is not allowed: in_ready is low when full.
- Simultaneous push and pop when empty is not possible: pop requires non-empty.
- Pointers are log2(DEPTH) bits and wrap. An extra occupancy bit distinguishes full from empty.
- FSM states: IDLE, LOAD_A, LOAD_B, WAIT_BUSY, WAIT_DONE.
- IDLE: go to LOAD_A when FIFO non-empty && adder_ready && !out_valid. Pop the head pair into an internal register. a=0.
- LOAD_A: a=pair.a for exactly one cycle, then go to LOAD_B.
- LOAD_B: a=pair.b for exactly one cycle, then go to WAIT_BUSY. a returns to 0 after this cycle.
- WAIT_BUSY: wait for adder_ready=0. If it never falls, wait indefinitely (or until timeout when FP_SEQ_TIMEOUT_EN is defined).
- WAIT_DONE: on the first cycle with adder_ready=1, capture sum into out_sum, set out_valid=1, go to IDLE.
- Launch latency: with a non-empty FIFO and adder_ready high, a carries operand A two cycles after the push.
- Result latency: out_valid rises one cycle after adder_ready rises.
- Result handshake: out_valid stays high and out_sum stays stable until out_valid && out_ready, then out_valid clears next cycle.
- A held result blocks new launches.
- No arithmetic is done here. Values pass through bit-exact, including NaN and denormal encodings.

Optional Feature:
FP_SEQ_TIMEOUT_EN
- Defined:
  - A counter runs while in WAIT_BUSY or WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES, timeout pulses for one cycle and the FSM returns to IDLE.
  - out_valid is not set and the pair is dropped.
  - The counter clears on every state entry.
- Undefined: no counter and no timeout port; the FSM waits indefinitely.

Decomposition:
- Package fp_seq_pkg contains:
  - typedef fp32_t (logic [31:0])
  - typedef operand_pair_t (struct: fp32_t a, b)
  - enum seq_state_t
  - constant FP_POS_ZERO = 32'h0000_0000
- One sub-module, fp_pair_fifo: a parameterised synchronous FIFO of operand_pair_t with full/empty flags.
- The FSM and result register stay in the top module.

Test Plan:
- Push (0x3F800000, 0xC0000000); bench adder model drops ready for 3 cycles -> a=0x3F800000 then 0xC0000000 on consecutive cycles; out_sum=0xBF800000 (-1.0), out_valid one cycle after ready rises.
- Push 5 pairs back-to-back with DEPTH=4 and adder_ready low -> in_ready low after 4 pushes; 5th accepted only after first pop; results emerge in push order.
- Hold out_ready=0 after first result -> out_valid stays high, out_sum stable; second pair not launched until handshake; then a shows the second pair.
- Assert reset during LOAD_B -> next cycle a=0, out_valid=0, in_ready=1, FIFO empty; a later push works normally.
- Pass 0x7FC00001 + 0x00000001 -> a carries these bit patterns unchanged.
- With FP_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, hold adder_ready=1 forever after load -> timeout pulses once 8 cycles after WAIT_BUSY entry; state returns to IDLE; no out_valid.
